feature_packer: RTL and testbench
=================================

FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 Parameter NUM_FEATURES, default 8, meaning: words per feature vector; SHALL be a power of two, 2 or more.
REQ-002 Parameter DATA_WIDTH, default 16, meaning: width of each signed feature word.
REQ-003 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port s_data  input  DATA_WIDTH  incoming feature word, signed two's complement.
REQ-006 Port s_valid  input  1  s_data is valid this cycle.
REQ-007 Port s_last  input  1  marks the final word of a frame; meaningful only when s_valid=1.
REQ-008 Port s_ready  output  1  packer accepts a word this cycle.
REQ-009 Port out_features_flat  output  NUM_FEATURES*DATA_WIDTH  assembled vector; feature k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-010 Port out_valid  output  1  one-cycle pulse; drives the downstream inference valid_in.
REQ-011 Port frame_err  output  1  one-cycle pulse for each discarded malformed frame.
REQ-012 Port frame_cnt  output  16  count of vectors emitted.

Function
REQ-013 Handshake: a word SHALL be accepted only in a cycle where s_valid=1 and s_ready=1.
REQ-014 Ordering: the k-th accepted word of a frame SHALL be written to feature slot k, with k counting from 0.
REQ-015 States: FILL, EMIT and DROP; s_ready SHALL be 1 in FILL and DROP and 0 in EMIT.
REQ-016 FILL: each accepted word SHALL increment the index idx, range 0..NUM_FEATURES-1.
REQ-017 FILL: accepting word NUM_FEATURES-1 under a valid completion condition SHALL move the block to EMIT and reset idx to 0.
REQ-018 EMIT, lasting exactly one cycle: the assembly buffer SHALL be copied into out_features_flat, and out_valid SHALL be 1 in that same cycle, i.e. one cycle after the final handshake.
REQ-019 EMIT: frame_cnt SHALL increment, wrapping 65535->0, and the block SHALL return to FILL.
REQ-020 out_features_flat SHALL hold its value between EMIT cycles; the assembly buffer SHALL be separate from it, so partial frames never appear on the output.
REQ-021 Throughput: the maximum rate SHALL be one vector every NUM_FEATURES+1 cycles, because of the single EMIT bubble.
REQ-022 No arithmetic, sign extension or truncation SHALL be applied; words SHALL pass through bit-exact.
REQ-023 out_valid and frame_err SHALL never be 1 in the same cycle.

Reset
REQ-024 When rst=1 at a clock edge, the following SHALL be cleared, with reset taking priority over any simultaneous handshake: state->FILL, idx->0, out_valid->0, frame_err->0, frame_cnt->0, out_features_flat->0, assembly buffer->0.
REQ-025 Reset mid-frame SHALL discard the partial frame, and the next accepted word SHALL be treated as feature 0.
REQ-026 s_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-027 Macro FEATURE_PACKER_TLAST_CHECK_EN SHALL compile s_last framing checks in or out.
REQ-028 With the macro, short frame: s_last=1 on a word with idx<NUM_FEATURES-1 SHALL discard the frame, pulse frame_err in the next cycle, reset idx to 0 and leave the block in FILL.
REQ-029 With the macro, long frame: word NUM_FEATURES-1 accepted with s_last=0 SHALL move the block to DROP.
REQ-030 With the macro, DROP SHALL discard words until one is accepted with s_last=1, then pulse frame_err in the next cycle and return to FILL, with no EMIT.
REQ-031 Without the macro, s_last SHALL be ignored, completion SHALL depend on count only, DROP SHALL be absent, and frame_err SHALL be constant 0.

Verification
REQ-032 Feed words 1..8 with s_valid=1 continuously and s_last on word 8 -> out_valid=1 one cycle after the 8th handshake, out_features_flat=0x0008_0007_0006_0005_0004_0003_0002_0001, frame_cnt=1, s_ready=0 for that one cycle.
REQ-033 Send two back-to-back frames, second one of all 0xFFFF -> exactly 2 out_valid pulses 9 cycles apart, second vector all ones, and the first vector held unchanged until the second EMIT.
REQ-034 Send 3 words, assert rst for 1 cycle, then send a full frame of 0x0010..0x0017 -> one out_valid with slot0=0x0010 and frame_cnt=1.
REQ-035 With the macro: s_last on word 5 -> frame_err pulse, no out_valid; a following valid frame is emitted correctly.
REQ-036 With the macro: 10-word frame with s_last on word 10 -> frame_err one cycle after word 10, no out_valid, frame_cnt unchanged.
REQ-037 Preload frame_cnt to 65535 via 65535 frames, then send one more frame -> frame_cnt=0 and out_valid still pulses.

Source files
------------

// File: rtl/feature_packer_if.sv
// Word-stream channel into feature_packer: data/valid/last from the source, ready back from the packer.
interface feature_packer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/feature_packer.sv
// Packs a stream of NUM_FEATURES signed words into one flat vector with a one-cycle EMIT bubble.
// Define FEATURE_PACKER_TLAST_CHECK_EN to enable s_last framing checks (short/long frame discard).
module feature_packer #(
    parameter int unsigned NUM_FEATURES = 8,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    feature_packer_if.slave                      s,
    output logic [NUM_FEATURES*DATA_WIDTH-1:0]   out_features_flat,
    output logic                                 out_valid,
    output logic                                 frame_err,
    output logic [15:0]                          frame_cnt
);
    localparam int unsigned IDX_W  = $clog2(NUM_FEATURES);
    localparam int unsigned FLAT_W = NUM_FEATURES * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

`ifdef FEATURE_PACKER_TLAST_CHECK_EN
    typedef enum logic [1:0] {FILL, EMIT, DROP} state_t;
`else
    typedef enum logic [1:0] {FILL, EMIT} state_t;
`endif

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [FLAT_W-1:0] asm_buf;
    logic [FLAT_W-1:0] asm_next;
    logic              s_ready_q;
    logic              accept;
    logic              at_end;
    logic              complete;

    assign s.s_ready = s_ready_q;
    assign accept    = s.s_valid && s_ready_q;
    assign at_end    = (idx == LAST_IDX);

`ifdef FEATURE_PACKER_TLAST_CHECK_EN
    logic short_frame;
    logic long_frame;
    assign complete    = at_end && s.s_last;
    assign short_frame = !at_end && s.s_last;
    assign long_frame  = at_end && !s.s_last;
`else
    logic unused_last;
    assign unused_last = s.s_last;
    assign complete    = at_end;
`endif

    // Assembly buffer with the current word merged into its slot
    always_comb begin
        asm_next = asm_buf;
        asm_next[32'(idx) * DATA_WIDTH +: DATA_WIDTH] = s.s_data;
    end

    // Output registers are loaded on the final handshake so they are visible during the EMIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FILL;
            idx               <= '0;
            asm_buf           <= '0;
            out_features_flat <= '0;
            out_valid         <= 1'b0;
            frame_err         <= 1'b0;
            frame_cnt         <= '0;
            s_ready_q         <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        asm_buf <= asm_next;
                        if (complete) begin
                            state             <= EMIT;
                            s_ready_q         <= 1'b0;
                            idx               <= '0;
                            out_features_flat <= asm_next;
                            out_valid         <= 1'b1;
                            frame_cnt         <= frame_cnt + 16'd1;
                        end
`ifdef FEATURE_PACKER_TLAST_CHECK_EN
                        else if (long_frame) begin
                            state <= DROP;
                            idx   <= '0;
                        end else if (short_frame) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end
`endif
                        else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    state     <= FILL;
                    s_ready_q <= 1'b1;
                end
`ifdef FEATURE_PACKER_TLAST_CHECK_EN
                // Swallow the rest of an over-long frame up to its s_last
                DROP: begin
                    if (accept && s.s_last) begin
                        state     <= FILL;
                        frame_err <= 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= FILL;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_feature_packer.sv
// Scoreboard bench for feature_packer: expected vectors queued at send time, popped on out_valid.
module tb_feature_packer;
    localparam int unsigned NF = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = NF * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] out_flat;
    logic          out_valid;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    feature_packer_if #(.DATA_WIDTH(DW)) bus ();

    feature_packer #(.NUM_FEATURES(NF), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .s                 (bus),
        .out_features_flat (out_flat),
        .out_valid         (out_valid),
        .frame_err         (frame_err),
        .frame_cnt         (frame_cnt)
    );

    typedef struct packed {
        logic [FW-1:0] vec;
        logic [15:0]   cnt;
    } exp_t;

    exp_t          exp_q[$];
    int            valid_cyc[$];
    int            n_vec   = 0;
    int            n_bad   = 0;
    int            exp_err = 0;
    int            cyc     = 0;
    logic [15:0]   model_cnt = '0;
    logic          mon_en  = 1'b0;
    logic [FW-1:0] held    = '0;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard on out_valid, otherwise checks the vector is held
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                held = '0;
            end else begin
                if (out_valid) begin
                    check("ready_in_emit", FW'(bus.s_ready), FW'(0));
                    check("valid_err_excl", FW'(frame_err), FW'(0));
                    valid_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("unexpected_vec", FW'(out_valid), FW'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("vec", out_flat, e.vec);
                        check("cnt", FW'(frame_cnt), FW'(e.cnt));
                    end
                    held = out_flat;
                end else begin
                    check("hold", out_flat, held);
                end
                if (frame_err) begin
                    check("err_expected", FW'(exp_err > 0), FW'(1));
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        int guard;
        guard = 0;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            guard++;
            if (guard > 20) begin
                check("ready_timeout", FW'(bus.s_ready), FW'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // last_pos is 1-based; 0 means no s_last in the frame
    task automatic send_frame(input logic [FW-1:0] vec, input int nwords, input int last_pos, input bit emits);
        if (emits) begin
            model_cnt = model_cnt + 16'd1;
            exp_q.push_back({vec, model_cnt});
        end
        for (int k = 0; k < nwords; k++) begin
            logic [DW-1:0] w;
            w = (k < int'(NF)) ? vec[k*DW +: DW] : DW'(16'hA000 + k);
            send_word(w, (k + 1) == last_pos);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_cnt = '0;
    endtask

    function automatic logic [FW-1:0] ramp(input logic [DW-1:0] base);
        logic [FW-1:0] v;
        for (int k = 0; k < int'(NF); k++) v[k*DW +: DW] = base + DW'(k);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] v;
        int n0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        held   = '0;
        mon_en = 1'b1;

        // Reset state and ready right after release
        @(negedge clk);
        check("rst_valid", FW'(out_valid), FW'(0));
        check("rst_err", FW'(frame_err), FW'(0));
        check("rst_cnt", FW'(frame_cnt), FW'(0));
        check("rst_flat", out_flat, FW'(0));
        check("rst_ready", FW'(bus.s_ready), FW'(1));
        @(posedge clk);
        #1;

        // Words 1..8, s_last on word 8
        v = ramp(16'h0001);
        check("ramp_model", v, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        send_frame(v, 8, 8, 1'b1);
        @(negedge clk);
        check("emit_latency", FW'(out_valid), FW'(1));
        check("emit_cnt1", FW'(frame_cnt), FW'(1));
        check("emit_ready0", FW'(bus.s_ready), FW'(0));
        @(negedge clk);
        check("emit_one_cycle", FW'(out_valid), FW'(0));
        @(posedge clk);
        #1;

        // Back-to-back frames, second all ones
        n0 = valid_cyc.size();
        send_frame(ramp(16'h1230), 8, 8, 1'b1);
        send_frame({FW{1'b1}}, 8, 8, 1'b1);
        idle(3);
        check("b2b_pulses", FW'(valid_cyc.size() - n0), FW'(2));
        if (valid_cyc.size() - n0 == 2)
            check("b2b_spacing", FW'(valid_cyc[n0+1] - valid_cyc[n0]), FW'(NF + 1));
        check("b2b_last_vec", out_flat, {FW{1'b1}});

        // Partial frame then reset: next word must land in slot 0
        send_word(16'h7777, 1'b0);
        send_word(16'h8888, 1'b0);
        send_word(16'h9999, 1'b0);
        do_reset();
        send_frame(ramp(16'h0010), 8, 8, 1'b1);
        idle(2);
        check("post_rst_slot0", FW'(out_flat[DW-1:0]), FW'(16'h0010));
        check("post_rst_cnt", FW'(frame_cnt), FW'(1));

        // Random data with gaps in s_valid
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < int'(NF); k++) v[k*DW +: DW] = DW'($urandom);
            model_cnt = model_cnt + 16'd1;
            exp_q.push_back({v, model_cnt});
            for (int k = 0; k < int'(NF); k++) begin
                send_word(v[k*DW +: DW], k == int'(NF) - 1);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(2);

`ifdef FEATURE_PACKER_TLAST_CHECK_EN
        // Short frame: s_last on word 5
        exp_err++;
        send_frame(ramp(16'h0500), 5, 5, 1'b0);
        @(negedge clk);
        check("short_err", FW'(frame_err), FW'(1));
        check("short_no_valid", FW'(out_valid), FW'(0));
        @(posedge clk);
        #1;
        send_frame(ramp(16'h0600), 8, 8, 1'b1);
        idle(2);
        // Long frame: 10 words, s_last on word 10
        v = out_flat;
        n0 = valid_cyc.size();
        exp_err++;
        send_frame(ramp(16'h0700), 10, 10, 1'b0);
        @(negedge clk);
        check("long_err", FW'(frame_err), FW'(1));
        check("long_no_valid", FW'(out_valid), FW'(0));
        check("long_cnt_same", FW'(frame_cnt), FW'(model_cnt));
        @(posedge clk);
        #1;
        check("long_no_pulse", FW'(valid_cyc.size() - n0), FW'(0));
        send_frame(ramp(16'h0800), 8, 8, 1'b1);
        idle(2);
`else
        // s_last is ignored: completion is by count only
        send_frame(ramp(16'h0500), 8, 3, 1'b1);
        send_frame(ramp(16'h0600), 8, 0, 1'b1);
        idle(2);
        check("no_err_pulse", FW'(exp_err), FW'(0));
`endif

        // Counter wrap: preload stands in for 65535 prior frames
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        model_cnt = 16'hFFFF;
        check("preload_cnt", FW'(frame_cnt), FW'(16'hFFFF));
        @(posedge clk);
        #1;
        n0 = valid_cyc.size();
        send_frame(ramp(16'h0900), 8, 8, 1'b1);
        idle(3);
        check("wrap_cnt", FW'(frame_cnt), FW'(0));
        check("wrap_pulse", FW'(valid_cyc.size() - n0), FW'(1));

        idle(4);
        check("scoreboard_empty", FW'(exp_q.size()), FW'(0));
        check("err_pending", FW'(exp_err), FW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
